// File: rtl/ray_fixed_pkg.sv
// Shared constants and FSM encoding for the ray fixed-point vector blocks.
// Component format: 19-bit sign-magnitude, bit18 sign, [17:0] magnitude
// with FRAC_BITS fractional bits.
package ray_fixed_pkg;

  localparam int unsigned COMP_WIDTH   = 19;
  localparam int unsigned FRAC_BITS    = 10;
  localparam int unsigned VECTOR_WIDTH = 3 * COMP_WIDTH;
  localparam int unsigned SIGN_BIT     = 18;
  localparam int unsigned MAG_WIDTH    = 18;

  localparam logic [MAG_WIDTH-1:0] MAG_MAX = 18'h3FFFF;

  // One state per component plus handshake states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CX   = 3'd1,
    ST_CY   = 3'd2,
    ST_CZ   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/sm_component_sub.sv
// Combinational sign-magnitude subtract of one component: diff = a - b.
// Ports:
//   a    in  19  minuend component
//   b    in  19  subtrahend component
//   diff out 19  difference (saturated or wrapped on overflow, never -0)
//   ovf  out 1   magnitude overflow
module sm_component_sub
  import ray_fixed_pkg::*;
#(
  parameter bit SATURATE = 1'b1
) (
  input  logic [COMP_WIDTH-1:0] a,
  input  logic [COMP_WIDTH-1:0] b,
  output logic [COMP_WIDTH-1:0] diff,
  output logic                  ovf
);

  logic                 w_sa;
  logic                 w_sb;
  logic [MAG_WIDTH-1:0] w_ma;
  logic [MAG_WIDTH-1:0] w_mb;
  logic [MAG_WIDTH:0]   w_sum;
  logic [MAG_WIDTH-1:0] w_mag;
  logic                 w_sign;

  // Subtraction is addition with the subtrahend's sign flipped.
  assign w_sa  = a[SIGN_BIT];
  assign w_sb  = ~b[SIGN_BIT];
  assign w_ma  = a[MAG_WIDTH-1:0];
  assign w_mb  = b[MAG_WIDTH-1:0];
  assign w_sum = {1'b0, w_ma} + {1'b0, w_mb};

  // Magnitude/sign selection with overflow handling.
  always_comb begin
    w_mag  = '0;
    w_sign = 1'b0;
    ovf    = 1'b0;
    if (w_sa == w_sb) begin
      w_sign = w_sa;
      ovf    = w_sum[MAG_WIDTH];
      if (w_sum[MAG_WIDTH] && SATURATE) begin
        w_mag = MAG_MAX;
      end else begin
        w_mag = w_sum[MAG_WIDTH-1:0];
      end
    end else if (w_ma >= w_mb) begin
      w_mag  = w_ma - w_mb;
      w_sign = w_sa;
    end else begin
      w_mag  = w_mb - w_ma;
      w_sign = w_sb;
    end
    // A zero magnitude is always reported as +0.
    if (w_mag == '0) begin
      w_sign = 1'b0;
    end
  end

  assign diff = {w_sign, w_mag};

endmodule

// File: rtl/signed_vector_subtraction_seq.sv
// Sequential {x,y,z} sign-magnitude vector subtract: out = v1 - v2, one
// component per cycle through a shared datapath, valid/ready on both sides.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   in_valid/ready input handshake (in_ready is combinational, IDLE only)
//   in_vector_1/2  57-bit minuend/subtrahend {x[56:38], y[37:19], z[18:0]}
//   out_valid/ready output handshake
//   out_vector     57-bit difference, same packing
//   out_overflow   per-component overflow {x, y, z}
module signed_vector_subtraction_seq
  import ray_fixed_pkg::*;
#(
  parameter bit SATURATE = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [VECTOR_WIDTH-1:0] in_vector_1,
  input  logic [VECTOR_WIDTH-1:0] in_vector_2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [VECTOR_WIDTH-1:0] out_vector,
  output logic [2:0]              out_overflow
);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [VECTOR_WIDTH-1:0] r_v1;
  logic [VECTOR_WIDTH-1:0] r_v2;
  logic [VECTOR_WIDTH-1:0] r_out_vector;
  logic [2:0]              r_out_overflow;
  logic                    r_out_valid;
  logic [COMP_WIDTH-1:0]   w_a;
  logic [COMP_WIDTH-1:0]   w_b;
  logic [COMP_WIDTH-1:0]   w_diff;
  logic                    w_ovf;

  assign in_ready     = (r_state == ST_IDLE);
  assign out_valid    = r_out_valid;
  assign out_vector   = r_out_vector;
  assign out_overflow = r_out_overflow;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid) w_state_nxt = ST_CX;
      ST_CX:   w_state_nxt = ST_CY;
      ST_CY:   w_state_nxt = ST_CZ;
      ST_CZ:   w_state_nxt = ST_DONE;
      ST_DONE: if (r_out_valid && out_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Component mux feeding the single subtractor.
  always_comb begin
    w_a = r_v1[COMP_WIDTH-1:0];
    w_b = r_v2[COMP_WIDTH-1:0];
    case (r_state)
      ST_CX: begin
        w_a = r_v1[3*COMP_WIDTH-1:2*COMP_WIDTH];
        w_b = r_v2[3*COMP_WIDTH-1:2*COMP_WIDTH];
      end
      ST_CY: begin
        w_a = r_v1[2*COMP_WIDTH-1:COMP_WIDTH];
        w_b = r_v2[2*COMP_WIDTH-1:COMP_WIDTH];
      end
      default: ;
    endcase
  end

  sm_component_sub #(
    .SATURATE (SATURATE)
  ) u_sub (
    .a    (w_a),
    .b    (w_b),
    .diff (w_diff),
    .ovf  (w_ovf)
  );

  // Operand capture and per-component result write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1           <= '0;
      r_v2           <= '0;
      r_out_vector   <= '0;
      r_out_overflow <= '0;
      r_out_valid    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_v1 <= in_vector_1;
            r_v2 <= in_vector_2;
          end
        end
        ST_CX: begin
          r_out_vector[3*COMP_WIDTH-1:2*COMP_WIDTH] <= w_diff;
          r_out_overflow[2]                         <= w_ovf;
        end
        ST_CY: begin
          r_out_vector[2*COMP_WIDTH-1:COMP_WIDTH] <= w_diff;
          r_out_overflow[1]                       <= w_ovf;
        end
        ST_CZ: begin
          r_out_vector[COMP_WIDTH-1:0] <= w_diff;
          r_out_overflow[0]            <= w_ovf;
          r_out_valid                  <= 1'b1;
        end
        ST_DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_vector_subtraction_seq.sv
// Self-checking bench: directed cases plus random vectors against an
// integer-arithmetic reference; a second instance covers wrap mode.
module tb_signed_vector_subtraction_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [56:0] in_vector_1;
  logic [56:0] in_vector_2;
  logic        out_valid;
  logic        out_ready;
  logic [56:0] out_vector;
  logic [2:0]  out_overflow;

  logic        in_ready_w;
  logic        out_valid_w;
  logic [56:0] out_vector_w;
  logic [2:0]  out_overflow_w;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  signed_vector_subtraction_seq #(.SATURATE(1'b1)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_vector_1  (in_vector_1),
    .in_vector_2  (in_vector_2),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_vector   (out_vector),
    .out_overflow (out_overflow)
  );

  signed_vector_subtraction_seq #(.SATURATE(1'b0)) u_dut_wrap (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready_w),
    .in_vector_1  (in_vector_1),
    .in_vector_2  (in_vector_2),
    .out_valid    (out_valid_w),
    .out_ready    (out_ready),
    .out_vector   (out_vector_w),
    .out_overflow (out_overflow_w)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: signed integer difference, then clamp or wrap the magnitude.
  function automatic logic [19:0] comp_ref(input logic [18:0] a, input logic [18:0] b,
                                           input bit sat);
    int ia, ib, r, mag;
    bit ov;
    ia  = a[18] ? -int'(a[17:0]) : int'(a[17:0]);
    ib  = b[18] ? -int'(b[17:0]) : int'(b[17:0]);
    r   = ia - ib;
    mag = (r < 0) ? -r : r;
    ov  = (mag > 262143);
    if (ov) mag = sat ? 262143 : (mag % 262144);
    return {ov, (r < 0) && (mag != 0), 18'(mag)};
  endfunction

  task automatic vec_ref(input logic [56:0] v1, input logic [56:0] v2, input bit sat,
                         output logic [56:0] vec, output logic [2:0] ovf);
    logic [19:0] rx, ry, rz;
    rx  = comp_ref(v1[56:38], v2[56:38], sat);
    ry  = comp_ref(v1[37:19], v2[37:19], sat);
    rz  = comp_ref(v1[18:0],  v2[18:0],  sat);
    vec = {rx[18:0], ry[18:0], rz[18:0]};
    ovf = {rx[19], ry[19], rz[19]};
  endtask

  task automatic check_result(input string tag, input logic [56:0] v1, input logic [56:0] v2);
    logic [56:0] ev;
    logic [2:0]  eo;
    vec_ref(v1, v2, 1'b1, ev, eo);
    check({tag, "_vec"}, 64'(out_vector), 64'(ev));
    check({tag, "_ovf"}, 64'(out_overflow), 64'(eo));
    vec_ref(v1, v2, 1'b0, ev, eo);
    check({tag, "_vec_wrap"}, 64'(out_vector_w), 64'(ev));
    check({tag, "_ovf_wrap"}, 64'(out_overflow_w), 64'(eo));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Count edges until out_valid, bounded; a timeout shows as a latency miss.
  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 12) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd3);
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 12) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, 64'(in_ready), 64'd1);
  endtask

  task automatic do_op(input string tag, input logic [56:0] v1, input logic [56:0] v2);
    wait_ready(tag);
    in_valid    = 1'b1;
    in_vector_1 = v1;
    in_vector_2 = v2;
    tick();
    in_valid = 1'b0;
    wait_out(tag);
    check_result(tag, v1, v2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drain_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_drain_ready"}, 64'(in_ready), 64'd1);
  endtask

  logic [56:0] va, vb, vc, vhold;
  int          acc_cycle[$];
  logic [56:0] q1[$];
  logic [56:0] q2[$];

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    in_vector_1 = '0;
    in_vector_2 = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_vec", 64'(out_vector), 64'd0);
    check("rst_ovf", 64'(out_overflow), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);

    // Mixed signs and -0 cancellation.
    do_op("basic", {19'h00C00, 19'h00400, 19'h40800}, {19'h00400, 19'h00C00, 19'h40800});
    check("basic_const", 64'(out_vector), 64'({19'h00800, 19'h40800, 19'h00000}));

    // Overflow: clamp vs wrap.
    do_op("sat", {19'h3FFFF, 19'h0, 19'h0}, {19'h40400, 19'h0, 19'h0});
    check("sat_x", 64'(out_vector[56:38]), 64'h3FFFF);
    check("wrap_x", 64'(out_vector_w[56:38]), 64'h003FF);
    check("sat_ovf", 64'(out_overflow), 64'b100);

    // Negative-zero inputs.
    do_op("negzero", {19'h40000, 19'h00000, 19'h0}, {19'h00000, 19'h40000, 19'h0});

    // Random vectors.
    for (int i = 0; i < 8; i++) begin
      va = 57'({$urandom(), $urandom()});
      vb = 57'({$urandom(), $urandom()});
      do_op("rand", va, vb);
    end

    // Backpressure in DONE with a new pair waiting.
    va = 57'({$urandom(), $urandom()});
    vb = 57'({$urandom(), $urandom()});
    vc = 57'({$urandom(), $urandom()});
    in_valid    = 1'b1;
    in_vector_1 = va;
    in_vector_2 = vb;
    tick();
    in_vector_1 = vc;
    in_vector_2 = va;
    wait_out("bp");
    check_result("bp", va, vb);
    vhold = out_vector;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("bp_hold_vec", 64'(out_vector), 64'(vhold));
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("bp_second_taken", 64'(in_ready), 64'd0);
    wait_out("bp2");
    check_result("bp2", vc, va);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset while in CY discards the partial result.
    in_valid    = 1'b1;
    in_vector_1 = {19'h00C00, 19'h00400, 19'h00001};
    in_vector_2 = {19'h40400, 19'h00C00, 19'h00002};
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_vec", 64'(out_vector), 64'd0);
    check("midrst_ovf", 64'(out_overflow), 64'd0);
    check("midrst_ready", 64'(in_ready), 64'd1);

    // Reset beats a simultaneous handshake.
    rst      = 1'b1;
    in_valid = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_vs_hs_ready", 64'(in_ready), 64'd1);
    do_op("after_rst", {19'h12345, 19'h54321, 19'h3FFFF}, {19'h40001, 19'h12345, 19'h7FFFF});

    // Throughput with both sides always ready.
    va = 57'({$urandom(), $urandom()});
    vb = 57'({$urandom(), $urandom()});
    in_valid    = 1'b1;
    out_ready   = 1'b1;
    in_vector_1 = va;
    in_vector_2 = vb;
    for (int c = 0; c < 20; c++) begin
      bit acc;
      acc = in_ready;
      if (acc) begin
        acc_cycle.push_back(c);
        q1.push_back(in_vector_1);
        q2.push_back(in_vector_2);
      end
      if (out_valid) begin
        if (q1.size() == 0) begin
          check("tp_unexpected_out", 64'd1, 64'd0);
        end else begin
          check_result("tp", q1.pop_front(), q2.pop_front());
        end
      end
      tick();
      if (acc) begin
        in_vector_1 = 57'({$urandom(), $urandom()});
        in_vector_2 = 57'({$urandom(), $urandom()});
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("tp_accepts", 64'(acc_cycle.size()), 64'd4);
    check("tp_pending", 64'(q1.size()), 64'd0);
    for (int i = 1; i < acc_cycle.size(); i++) begin
      check("tp_spacing", 64'(acc_cycle[i] - acc_cycle[i-1]), 64'd5);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
